// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
//   Request/acknowledge bus between the load/store unit and a variable-latency
//   data memory.
//   master (LSU side):    drives mem_req, mem_we, mem_addr, mem_be, mem_wdata;
//                         samples mem_ack, mem_rdata
//   slave (memory side):  samples the request fields; drives mem_ack, mem_rdata
//   mem_req    1   request, held high until mem_ack
//   mem_we     1   1 = write
//   mem_addr   32  word-aligned address
//   mem_be     4   byte enables
//   mem_wdata  32  lane-replicated store data
//   mem_ack    1   access complete; mem_rdata valid in the same cycle for reads
//   mem_rdata  32  read word
// -----------------------------------------------------------------------------
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Sits after the ALU/register-file stage of a single-cycle core and replaces
//   the ideal data memory. Performs byte/half/word loads and stores over a
//   req/ack bus, stalls the core until the access completes, and returns the
//   sign/zero-extended load data.
// Parameters
//   TIMEOUT_CYCLES  ACCESS cycles without mem_ack before the access is aborted
//                   with bus_err (1..65535)
// Ports
//   clk, reset   clock and synchronous active-high reset
//   MemRead      load request
//   MemWrite     store request (wins over MemRead)
//   funct3       access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   A, WD        byte effective address, right-aligned store data
//   RD           extended load data, valid in the DONE cycle, else 0
//   Stall        hold PC and suppress RegWrite while high
//   fault        misaligned address or illegal funct3 (no bus access)
//   bus_err      timed-out access, high in its DONE cycle
//   bus          memory bus (master side)
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  input  logic [2:0]               funct3,
  input  logic [31:0]              A,
  input  logic [31:0]              WD,
  output logic [31:0]              RD,
  output logic                     Stall,
  output logic                     fault,
  output logic                     bus_err,
  load_store_unit_if.master        bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] rdata_q, rdata_d;
  logic        berr_q, berr_d;
  // Blocks new requests in the first cycle out of reset so every output
  // reads 0 there, whatever the core presents.
  logic        hold_q, hold_d;

  logic        req_ok;
  logic        legal_f3;
  logic        aligned;

  // Byte enables of a store for its size and address offset.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << lo;
      2'b01:   store_be = 4'b0011 << {lo[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across all lanes it could land in, so the
  // byte enables alone select the written bytes.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  // Pick the addressed byte/half from the read word and extend it.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'd0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = word;
    endcase
  endfunction

  always_comb begin
    req_ok = (MemRead | MemWrite) & ~hold_q;

    case (funct3)
      3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
      3'b100, 3'b101:         legal_f3 = ~MemWrite;   // unsigned forms are load-only
      default:                legal_f3 = 1'b0;
    endcase

    case (funct3[1:0])
      2'b01:   aligned = ~A[0];
      2'b10:   aligned = (A[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    rdata_d = rdata_q;
    berr_d  = berr_q;
    hold_d  = 1'b0;
    Stall   = 1'b0;
    fault   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_ok) begin
          if (!legal_f3 || !aligned) begin
            fault = 1'b1;
          end else begin
            Stall   = 1'b1;
            we_d    = MemWrite;
            addr_d  = {A[31:2], 2'b00};
            be_d    = MemWrite ? store_be(funct3, A[1:0]) : 4'b1111;
            wdata_d = MemWrite ? store_data(funct3, WD) : 32'd0;
            f3_d    = funct3;
            lane_d  = A[1:0];
            cnt_d   = 16'd0;
            berr_d  = 1'b0;
            rdata_d = 32'd0;
            state_d = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        Stall = 1'b1;
        cnt_d = cnt_q + 16'd1;
        if (bus.mem_ack) begin
          rdata_d = we_q ? 32'd0 : load_ext(f3_q, lane_q, bus.mem_rdata);
          berr_d  = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = 32'd0;
          berr_d  = 1'b1;
          state_d = ST_DONE;
        end
      end

      // The committing instruction is still on the inputs here; ignore it.
      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    bus.mem_req   = (state_q == ST_ACCESS);
    bus.mem_we    = (state_q == ST_ACCESS) & we_q;
    bus.mem_addr  = (state_q == ST_ACCESS) ? addr_q  : 32'd0;
    bus.mem_be    = (state_q == ST_ACCESS) ? be_q    : 4'd0;
    bus.mem_wdata = (state_q == ST_ACCESS) ? wdata_q : 32'd0;
    RD            = (state_q == ST_DONE)   ? rdata_q : 32'd0;
    bus_err       = (state_q == ST_DONE) & berr_q;

    // Everything reads 0 while reset is held, including an access in flight.
    if (reset) begin
      Stall         = 1'b0;
      fault         = 1'b0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = 32'd0;
      bus.mem_be    = 4'd0;
      bus.mem_wdata = 32'd0;
      RD            = 32'd0;
      bus_err       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      lane_q  <= 2'd0;
      rdata_q <= 32'd0;
      berr_q  <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      rdata_q <= rdata_d;
      berr_q  <= berr_d;
      hold_q  <= hold_d;
    end
  end

endmodule
